decode_stage_param: RTL and testbench
=====================================

# decode_stage_param

Parametrised successor to the pipelined Y86-64 decode stage. It holds a configurable register file and decodes source and destination IDs for every icode. It forwards operands from the e/M/W stages, detects load-use hazards, and loads the E pipeline register with reset, stall and bubble control. It sits between the F/D pipeline register and the execute stage.

## Interface
- XLEN, 64, datapath width
- NREG, 15, architectural registers (IDs 0..NREG-1)
- RNONE, 4'hF, "no register" ID
- RSP_ID, 4, stack pointer ID
- RSP_INIT, 256, reset value of RSP_ID; all other registers reset to 0
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- D_icode, D_ifun, D_rA, D_rB  in  4 each  decode-stage fields
- D_valC, D_valP  in  XLEN  constant and next PC
- D_stat  in  4  status
- e_dstE, M_dstE, M_dstM, W_dstE, W_dstM  in  4 each  downstream destinations
- e_valE, M_valE, m_valM, W_valE, W_valM  in  XLEN each  downstream values
- E_stall, E_bubble  in  1 each  E register control
- d_srcA, d_srcB  out  4 each  decoded sources (combinational)
- load_use  out  1  load-use hazard (combinational)
- E_icode, E_ifun, E_srcA, E_srcB, E_dstE, E_dstM  out  4 each  E register
- E_valA, E_valB, E_valC  out  XLEN each  E register
- E_stat  out  4  E register
- reg_dump  out  NREG*XLEN  register file image; register i occupies [i*XLEN +: XLEN]

## Operation
- Decode table. Any ID not listed is RNONE.
  - cmovXX: srcA=rA, dstE=rB
  - irmovq: dstE=rB
  - rmmovq: srcA=rA, srcB=rB
  - mrmovq: srcB=rB, dstM=rA
  - OPq: srcA=rA, srcB=rB, dstE=rB
  - call: srcB=dstE=RSP
  - ret: srcA=srcB=dstE=RSP
  - pushq: srcA=rA, srcB=dstE=RSP
  - popq: srcA=srcB=dstE=RSP, dstM=rA
  - halt, nop, jXX and illegal icodes: all RNONE
- valA select:
  - call or jXX: D_valP.
  - Otherwise the first match in priority e_dstE, M_dstM, M_dstE, W_dstM, W_dstE.
  - Falls back to the register file value.
- valB select: same priority chain, without the valP case.
- A source equal to RNONE never matches; its value is 0.
- Write-back:
  - At posedge, W_dstE writes W_valE and W_dstM writes W_valM.
  - A port whose destination is RNONE or >= NREG does not write.
  - If W_dstE == W_dstM, W_valM wins.
- load_use = (E_icode is mrmovq or popq) and E_dstM != RNONE and E_dstM matches d_srcA or d_srcB.
- E register priority: reset > E_bubble > E_stall (hold) > load decoded values.
- Bubble and reset value of the E register:
  - icode=1 (nop), ifun=0, stat=1 (AOK)
  - srcA/srcB/dstE/dstM = RNONE
  - valA/valB/valC = 0
- reset also restores the register file (RSP_ID=RSP_INIT, others 0). Reset mid-operation discards any W write in the same cycle.

## Timing
- Decode, forwarding and hazard logic: combinational.
- D to E latency: 1 cycle.
- A register write at edge N is visible to a register-file read after edge N.
- A same-cycle read of that register is served by the W forwarding path.
- load_use is valid in the same cycle as D_*. The external controller must assert E_bubble and stall F/D for exactly one cycle.

## Configuration
- Macro DECODE_FWD_EN.
- Defined: forwarding as described above.
- Undefined:
  - valA/valB come from the register file only (plus valP for call/jXX).
  - load_use also asserts when a non-RNONE d_srcA or d_srcB matches any of E_dstE, E_dstM, M_dstE, M_dstM, W_dstE, W_dstM.
  - The result is a data-hazard stall until write-back retires.

## Structure
- Shared package y86_pkg:
  - icode constants (IHALT..IPOPQ)
  - RNONE, RSP_ID
  - stat codes (SAOK=1, SHLT, SADR, SINS)
  - E-register struct typedef and its bubble constant
- One sub-module, regfile_2w: NREG x XLEN storage, two write ports, two combinational read ports, reset init, reg_dump output.

## Test plan
- Reset: reset=1 for 1 cycle -> reg_dump RSP=256, others 0; E_icode=1, E_dstE=F, E_stat=1.
- Write-back: W_dstE=3, W_valE=5 -> next cycle an OPq decoding rB=3 reads valB=5 with no forwarding sources active. With W_dstE=W_dstM=2, W_valE=7, W_valM=9 -> register 2 = 9.
- Forwarding priority: d_srcA=2, e_dstE=2/e_valE=11, M_dstE=2/M_valE=22 -> E_valA=11 next cycle. With e_dstE=F -> 22.
- Load-use: E_icode=mrmovq, E_dstM=3, decoded OPq rA=3 -> load_use=1. E_bubble=1 -> E_icode=1 next cycle.
- Stall vs bubble: E_stall=1 holds the E register for 3 cycles. E_stall=E_bubble=1 -> bubble loaded.
- call: D_valP=0x40 -> E_valA=0x40, E_srcB=E_dstE=4, E_valB=current RSP value. Without DECODE_FWD_EN, an M_dstE=4 conflict -> load_use=1.

Source files
------------

// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 icodes, register IDs, status codes and E-register control struct
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE  = 4'hF;
  localparam logic [3:0] RSP_ID = 4'h4;

  localparam logic [3:0] SAOK = 4'h1;
  localparam logic [3:0] SHLT = 4'h2;
  localparam logic [3:0] SADR = 4'h3;
  localparam logic [3:0] SINS = 4'h4;

  // Control half of the E register; the XLEN-wide values live beside it in the top.
  typedef struct packed {
    logic [3:0] icode;
    logic [3:0] ifun;
    logic [3:0] stat;
    logic [3:0] src_a;
    logic [3:0] src_b;
    logic [3:0] dst_e;
    logic [3:0] dst_m;
  } e_ctl_t;

  localparam e_ctl_t E_CTL_BUBBLE = '{icode: INOP, ifun: 4'h0, stat: SAOK,
                                      src_a: RNONE, src_b: RNONE,
                                      dst_e: RNONE, dst_m: RNONE};

endpackage

// File: rtl/regfile_2w.sv
// rtl/regfile_2w.sv - NREG x XLEN register file, two write ports (port M wins), two async read ports
module regfile_2w #(
  parameter int              XLEN     = 64,
  parameter int              NREG     = 15,
  parameter logic [3:0]      RNONE    = 4'hF,
  parameter logic [3:0]      RSP_ID   = 4'd4,
  parameter logic [XLEN-1:0] RSP_INIT = XLEN'(256)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           wr_e_id,
  input  logic [XLEN-1:0]      wr_e_data,
  input  logic [3:0]           wr_m_id,
  input  logic [XLEN-1:0]      wr_m_data,
  input  logic [3:0]           rd_a_id,
  output logic [XLEN-1:0]      rd_a_data,
  input  logic [3:0]           rd_b_id,
  output logic [XLEN-1:0]      rd_b_data,
  output logic [NREG*XLEN-1:0] reg_dump
);

  logic [XLEN-1:0] regs [NREG];
  logic            wr_e_en, wr_m_en;

  assign wr_e_en = (wr_e_id != RNONE) && (int'(wr_e_id) < NREG);
  assign wr_m_en = (wr_m_id != RNONE) && (int'(wr_m_id) < NREG);

  // Port M is written second so it overrides port E on a shared destination.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= (i == int'(RSP_ID)) ? RSP_INIT : '0;
    end else begin
      if (wr_e_en) regs[wr_e_id] <= wr_e_data;
      if (wr_m_en) regs[wr_m_id] <= wr_m_data;
    end
  end

  assign rd_a_data = (int'(rd_a_id) < NREG) ? regs[rd_a_id] : '0;
  assign rd_b_data = (int'(rd_b_id) < NREG) ? regs[rd_b_id] : '0;

  for (genvar g = 0; g < NREG; g++) begin : g_dump
    assign reg_dump[g*XLEN +: XLEN] = regs[g];
  end

endmodule

// File: rtl/decode_stage_param.sv
// rtl/decode_stage_param.sv - Y86-64 decode stage with register file, hazard detect and E register; DECODE_FWD_EN enables forwarding
module decode_stage_param #(
  parameter int              XLEN     = 64,
  parameter int              NREG     = 15,
  parameter logic [3:0]      RNONE    = 4'hF,
  parameter logic [3:0]      RSP_ID   = 4'd4,
  parameter logic [XLEN-1:0] RSP_INIT = XLEN'(256)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           D_icode,
  input  logic [3:0]           D_ifun,
  input  logic [3:0]           D_rA,
  input  logic [3:0]           D_rB,
  input  logic [XLEN-1:0]      D_valC,
  input  logic [XLEN-1:0]      D_valP,
  input  logic [3:0]           D_stat,
  input  logic [3:0]           e_dstE,
  input  logic [3:0]           M_dstE,
  input  logic [3:0]           M_dstM,
  input  logic [3:0]           W_dstE,
  input  logic [3:0]           W_dstM,
  input  logic [XLEN-1:0]      e_valE,
  input  logic [XLEN-1:0]      M_valE,
  input  logic [XLEN-1:0]      m_valM,
  input  logic [XLEN-1:0]      W_valE,
  input  logic [XLEN-1:0]      W_valM,
  input  logic                 E_stall,
  input  logic                 E_bubble,
  output logic [3:0]           d_srcA,
  output logic [3:0]           d_srcB,
  output logic                 load_use,
  output logic [3:0]           E_icode,
  output logic [3:0]           E_ifun,
  output logic [3:0]           E_srcA,
  output logic [3:0]           E_srcB,
  output logic [3:0]           E_dstE,
  output logic [3:0]           E_dstM,
  output logic [XLEN-1:0]      E_valA,
  output logic [XLEN-1:0]      E_valB,
  output logic [XLEN-1:0]      E_valC,
  output logic [3:0]           E_stat,
  output logic [NREG*XLEN-1:0] reg_dump
);
  import y86_pkg::*;

  logic [3:0]      d_dstE, d_dstM;
  logic [XLEN-1:0] rf_a, rf_b, d_valA, d_valB;
  e_ctl_t          e_ctl_q;
  logic [XLEN-1:0] e_valA_q, e_valB_q, e_valC_q;

  always_comb begin
    d_srcA = RNONE;
    d_srcB = RNONE;
    d_dstE = RNONE;
    d_dstM = RNONE;
    case (D_icode)
      IRRMOVQ: begin d_srcA = D_rA; d_dstE = D_rB; end
      IIRMOVQ: d_dstE = D_rB;
      IRMMOVQ: begin d_srcA = D_rA; d_srcB = D_rB; end
      IMRMOVQ: begin d_srcB = D_rB; d_dstM = D_rA; end
      IOPQ:    begin d_srcA = D_rA; d_srcB = D_rB; d_dstE = D_rB; end
      ICALL:   begin d_srcB = RSP_ID; d_dstE = RSP_ID; end
      IRET:    begin d_srcA = RSP_ID; d_srcB = RSP_ID; d_dstE = RSP_ID; end
      IPUSHQ:  begin d_srcA = D_rA; d_srcB = RSP_ID; d_dstE = RSP_ID; end
      IPOPQ:   begin d_srcA = RSP_ID; d_srcB = RSP_ID; d_dstE = RSP_ID; d_dstM = D_rA; end
      default: ;
    endcase
  end

  regfile_2w #(
    .XLEN(XLEN), .NREG(NREG), .RNONE(RNONE), .RSP_ID(RSP_ID), .RSP_INIT(RSP_INIT)
  ) u_regfile (
    .clk(clk), .reset(reset),
    .wr_e_id(W_dstE), .wr_e_data(W_valE),
    .wr_m_id(W_dstM), .wr_m_data(W_valM),
    .rd_a_id(d_srcA), .rd_a_data(rf_a),
    .rd_b_id(d_srcB), .rd_b_data(rf_b),
    .reg_dump(reg_dump)
  );

`ifdef DECODE_FWD_EN
  // Youngest producer first; W covers the register being written this very edge.
  function automatic logic [XLEN-1:0] sel_val(input logic [3:0] src, input logic [XLEN-1:0] rf);
    if (src == RNONE)       return '0;
    else if (src == e_dstE) return e_valE;
    else if (src == M_dstM) return m_valM;
    else if (src == M_dstE) return M_valE;
    else if (src == W_dstM) return W_valM;
    else if (src == W_dstE) return W_valE;
    else                    return rf;
  endfunction

  assign load_use = ((e_ctl_q.icode == IMRMOVQ) || (e_ctl_q.icode == IPOPQ)) &&
                    (e_ctl_q.dst_m != RNONE) &&
                    ((e_ctl_q.dst_m == d_srcA) || (e_ctl_q.dst_m == d_srcB));
`else
  function automatic logic [XLEN-1:0] sel_val(input logic [3:0] src, input logic [XLEN-1:0] rf);
    return (src == RNONE) ? '0 : rf;
  endfunction

  // Without bypass paths any in-flight writer of a source must drain before decode proceeds.
  function automatic logic pending(input logic [3:0] src);
    return (src != RNONE) &&
           ((src == e_ctl_q.dst_e) || (src == e_ctl_q.dst_m) ||
            (src == M_dstE) || (src == M_dstM) ||
            (src == W_dstE) || (src == W_dstM));
  endfunction

  assign load_use = pending(d_srcA) || pending(d_srcB);

  logic unused_fwd;
  assign unused_fwd = ^{e_dstE, e_valE, M_valE, m_valM};
`endif

  assign d_valA = ((D_icode == ICALL) || (D_icode == IJXX)) ? D_valP : sel_val(d_srcA, rf_a);
  assign d_valB = sel_val(d_srcB, rf_b);

  always_ff @(posedge clk) begin
    if (reset || E_bubble) begin
      e_ctl_q  <= E_CTL_BUBBLE;
      e_valA_q <= '0;
      e_valB_q <= '0;
      e_valC_q <= '0;
    end else if (!E_stall) begin
      e_ctl_q  <= '{icode: D_icode, ifun: D_ifun, stat: D_stat,
                    src_a: d_srcA, src_b: d_srcB, dst_e: d_dstE, dst_m: d_dstM};
      e_valA_q <= d_valA;
      e_valB_q <= d_valB;
      e_valC_q <= D_valC;
    end
  end

  assign E_icode = e_ctl_q.icode;
  assign E_ifun  = e_ctl_q.ifun;
  assign E_stat  = e_ctl_q.stat;
  assign E_srcA  = e_ctl_q.src_a;
  assign E_srcB  = e_ctl_q.src_b;
  assign E_dstE  = e_ctl_q.dst_e;
  assign E_dstM  = e_ctl_q.dst_m;
  assign E_valA  = e_valA_q;
  assign E_valB  = e_valB_q;
  assign E_valC  = e_valC_q;

endmodule

// File: tb/tb_decode_stage_param.sv
// tb/tb_decode_stage_param.sv - directed bench for decode_stage_param, default or DECODE_FWD_EN build
module tb_decode_stage_param;

  localparam int XLEN = 64;
  localparam int NREG = 15;

`ifdef DECODE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic [3:0]           D_icode, D_ifun, D_rA, D_rB, D_stat;
  logic [XLEN-1:0]      D_valC, D_valP;
  logic [3:0]           e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [XLEN-1:0]      e_valE, M_valE, m_valM, W_valE, W_valM;
  logic                 E_stall, E_bubble;
  logic [3:0]           d_srcA, d_srcB;
  logic                 load_use;
  logic [3:0]           E_icode, E_ifun, E_srcA, E_srcB, E_dstE, E_dstM, E_stat;
  logic [XLEN-1:0]      E_valA, E_valB, E_valC;
  logic [NREG*XLEN-1:0] reg_dump;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  decode_stage_param dut (
    .clk(clk), .reset(reset),
    .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP), .D_stat(D_stat),
    .e_dstE(e_dstE), .M_dstE(M_dstE), .M_dstM(M_dstM), .W_dstE(W_dstE), .W_dstM(W_dstM),
    .e_valE(e_valE), .M_valE(M_valE), .m_valM(m_valM), .W_valE(W_valE), .W_valM(W_valM),
    .E_stall(E_stall), .E_bubble(E_bubble),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .load_use(load_use),
    .E_icode(E_icode), .E_ifun(E_ifun), .E_srcA(E_srcA), .E_srcB(E_srcB),
    .E_dstE(E_dstE), .E_dstM(E_dstM),
    .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC), .E_stat(E_stat),
    .reg_dump(reg_dump)
  );

  function automatic logic [XLEN-1:0] rd(input int i);
    return reg_dump[i*XLEN +: XLEN];
  endfunction

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [3:0] icode, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [XLEN-1:0] valc, input logic [XLEN-1:0] valp);
    D_icode = icode; D_ifun = 4'h0; D_rA = ra; D_rB = rb;
    D_valC = valc; D_valP = valp; D_stat = 4'h1;
  endtask

  initial begin
    reset = 1'b1;
    set_d(4'h1, 4'hF, 4'hF, '0, '0);
    e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
    e_valE = '0; M_valE = '0; m_valM = '0; W_valE = '0; W_valM = '0;
    E_stall = 1'b0; E_bubble = 1'b0;

    tick();
    reset = 1'b0;
    check("rst_rsp", rd(4), 64'd256);
    check("rst_r0", rd(0), 64'd0);
    check("rst_r3", rd(3), 64'd0);
    check("rst_E_icode", E_icode, 4'h1);
    check("rst_E_dstE", E_dstE, 4'hF);
    check("rst_E_stat", E_stat, 4'h1);
    check("rst_E_valA", E_valA, 64'd0);

    W_dstE = 4'd3; W_valE = 64'd5;
    tick();
    W_dstE = 4'hF; W_valE = '0;
    check("wb_r3", rd(3), 64'd5);
    set_d(4'h6, 4'd1, 4'd3, '0, '0);
    #1;
    check("opq_srcA", d_srcA, 4'd1);
    check("opq_srcB", d_srcB, 4'd3);
    check("opq_lu", load_use, 1'b0);
    tick();
    check("opq_E_valB", E_valB, 64'd5);
    check("opq_E_icode", E_icode, 4'h6);
    check("opq_E_dstE", E_dstE, 4'd3);
    check("opq_E_valA", E_valA, 64'd0);
    set_d(4'h1, 4'hF, 4'hF, '0, '0);

    W_dstE = 4'd2; W_valE = 64'd7; W_dstM = 4'd2; W_valM = 64'd9;
    tick();
    W_dstE = 4'hF; W_dstM = 4'hF; W_valE = '0; W_valM = '0;
    check("wb_both_r2", rd(2), 64'd9);

    set_d(4'h6, 4'd2, 4'd3, '0, '0);
    e_dstE = 4'd2; e_valE = 64'd11; M_dstE = 4'd2; M_valE = 64'd22;
    #1;
    check("fwd_lu", load_use, FWD ? 1'b0 : 1'b1);
    tick();
    check("fwd_e_valA", E_valA, FWD ? 64'd11 : 64'd9);
    check("fwd_e_valB", E_valB, 64'd5);
    e_dstE = 4'hF;
    tick();
    check("fwd_M_valA", E_valA, FWD ? 64'd22 : 64'd9);
    M_dstE = 4'hF; M_valE = '0;

    set_d(4'h3, 4'hF, 4'd5, 64'h99, '0);
    e_valE = 64'h77;
    tick();
    check("rnone_valA", E_valA, 64'd0);
    check("rnone_valB", E_valB, 64'd0);
    check("irmov_valC", E_valC, 64'h99);
    check("irmov_dstE", E_dstE, 4'd5);
    check("irmov_srcA", E_srcA, 4'hF);
    e_valE = '0;

    set_d(4'h5, 4'd3, 4'd1, 64'd8, '0);
    tick();
    check("mrmov_E_icode", E_icode, 4'h5);
    check("mrmov_E_dstM", E_dstM, 4'd3);
    set_d(4'h6, 4'd1, 4'd2, '0, '0);
    #1;
    check("lu_nomatch", load_use, 1'b0);
    D_rA = 4'd3;
    #1;
    check("lu_match", load_use, 1'b1);
    E_bubble = 1'b1;
    tick();
    E_bubble = 1'b0;
    check("bub_E_icode", E_icode, 4'h1);
    check("bub_E_dstM", E_dstM, 4'hF);
    #1;
    check("lu_after_bub", load_use, 1'b0);

    set_d(4'h3, 4'hF, 4'd6, 64'h123, '0);
    tick();
    check("ld_E_icode", E_icode, 4'h3);
    check("ld_E_valC", E_valC, 64'h123);
    set_d(4'h6, 4'd1, 4'd2, '0, '0);
    E_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_icode", E_icode, 4'h3);
      check("stall_valC", E_valC, 64'h123);
      check("stall_dstE", E_dstE, 4'd6);
    end
    E_bubble = 1'b1;
    tick();
    check("stbub_icode", E_icode, 4'h1);
    check("stbub_valC", E_valC, 64'd0);
    E_stall = 1'b0; E_bubble = 1'b0;

    set_d(4'h8, 4'hF, 4'hF, 64'h1000, 64'h40);
    M_dstE = 4'd4; M_valE = 64'h55;
    #1;
    check("call_srcA", d_srcA, 4'hF);
    check("call_srcB", d_srcB, 4'd4);
    check("call_lu", load_use, FWD ? 1'b0 : 1'b1);
    M_dstE = 4'hF; M_valE = '0;
    tick();
    check("call_valA", E_valA, 64'h40);
    check("call_E_srcB", E_srcB, 4'd4);
    check("call_E_dstE", E_dstE, 4'd4);
    check("call_valB", E_valB, 64'd256);

    reset = 1'b1;
    W_dstE = 4'd3; W_valE = 64'hAA;
    tick();
    reset = 1'b0;
    W_dstE = 4'hF; W_valE = '0;
    check("rst2_r3", rd(3), 64'd0);
    check("rst2_r2", rd(2), 64'd0);
    check("rst2_rsp", rd(4), 64'd256);
    check("rst2_E_icode", E_icode, 4'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
